loom_dpi_ctrl: RTL and testbench

- FPGA-side controller for the host communication interface. It consumes DPI call signaling from the transformed DUT and gates the DUT clock enable.
- It freezes the DUT on every DPI call and exposes func_id and args to the host through a 64-bit memory-mapped register window.
- The host writes the return value and releases the DUT. The block sits between the DUT and the host bridge (simulation stub or PCIe).

---
 rtl/loom_dpi_ctrl_pkg.sv | 34 +++
 rtl/loom_dpi_ctrl_if.sv | 28 ++
 rtl/loom_dpi_ctrl_regfile.sv | 94 +++++++++
 rtl/loom_dpi_ctrl.sv | 119 +++++++++++
 tb/tb_loom_dpi_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loom_dpi_ctrl_pkg.sv
// Shared definitions for the DPI host controller: register map, CONTROL and
// STATUS bit positions, the controller state type and an argument-word helper.
package loom_dpi_pkg;

    // 64-bit register window, byte addresses (bits [2:0] are ignored on decode)
    localparam logic [31:0] REG_STATUS    = 32'h0000_0000;
    localparam logic [31:0] REG_FUNC_ID   = 32'h0000_0008;
    localparam logic [31:0] REG_RESULT    = 32'h0000_0010;
    localparam logic [31:0] REG_CONTROL   = 32'h0000_0018;
    localparam logic [31:0] REG_CYCLE_CNT = 32'h0000_0020;
    localparam logic [31:0] REG_CALL_CNT  = 32'h0000_0028;
    localparam logic [31:0] REG_ARGS_BASE = 32'h0000_0100;

    // CONTROL bits
    localparam int CTRL_COMPLETE_BIT = 0;
    localparam int CTRL_RUN_BIT      = 1;

    // STATUS bits
    localparam int STAT_PENDING_BIT  = 0;
    localparam int STAT_RUN_BIT      = 1;
    localparam int STAT_RELEASE_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RELEASE = 2'd2
    } dpi_state_e;

    // Number of 64-bit words needed to expose an argument vector of width w
    function automatic int num_arg_words(input int w);
        return (w + 63) / 64;
    endfunction

endpackage

// File: rtl/loom_dpi_ctrl_if.sv
// Host register-window bus between the host bridge and the DPI controller.
//   host_req   : request strobe, one cycle per request
//   host_wr    : 1 = write, 0 = read
//   host_addr  : byte address, bits [2:0] ignored
//   host_wdata : write data
//   host_rdata : read data, valid only in the ack cycle, otherwise 0
//   host_ack   : completion strobe
// Handshake: there is no backpressure. Every cycle with host_req=1 is one
// request, and it is answered by host_ack=1 exactly one cycle later, so
// back-to-back requests are acknowledged back-to-back in issue order.
interface loom_dpi_ctrl_if;
    logic        host_req;
    logic        host_wr;
    logic [31:0] host_addr;
    logic [63:0] host_wdata;
    logic [63:0] host_rdata;
    logic        host_ack;

    modport master (
        output host_req, host_wr, host_addr, host_wdata,
        input  host_rdata, host_ack
    );

    modport slave (
        input  host_req, host_wr, host_addr, host_wdata,
        output host_rdata, host_ack
    );
endinterface

// File: rtl/loom_dpi_ctrl_regfile.sv
// Register window of the DPI controller: address decode, write strobes for the
// writable registers, read mux (including the argument words) and the
// registered ack/rdata pair.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   bus              host bus (slave side)
//   state_i, run_i   controller state and run flag for STATUS/CONTROL reads
//   func_id_i        captured function id
//   result_i         RESULT register contents
//   cycle_cnt_i      enabled-cycle counter
//   call_cnt_i       captured-call counter
//   args_i           captured argument vector
//   result_we_o      host write to RESULT this cycle
//   control_we_o     host write to CONTROL this cycle
module loom_dpi_regfile
    import loom_dpi_pkg::*;
#(
    parameter int FUNC_ID_WIDTH = 8,
    parameter int MAX_ARG_WIDTH = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    loom_dpi_ctrl_if.slave           bus,
    input  dpi_state_e               state_i,
    input  logic                     run_i,
    input  logic [FUNC_ID_WIDTH-1:0] func_id_i,
    input  logic [63:0]              result_i,
    input  logic [63:0]              cycle_cnt_i,
    input  logic [31:0]              call_cnt_i,
    input  logic [MAX_ARG_WIDTH-1:0] args_i,
    output logic                     result_we_o,
    output logic                     control_we_o
);
    localparam int NUM_ARG_WORDS = num_arg_words(MAX_ARG_WIDTH);
    localparam int ARGS_PAD_W    = NUM_ARG_WORDS * 64;

    logic [31:0]           addr_w;
    logic [31:0]           arg_off;
    logic                  arg_hit;
    logic [ARGS_PAD_W-1:0] args_pad;
    logic [63:0]           rd_mux;
    logic                  ack_q;
    logic [63:0]           rdata_q;
    logic                  unused_addr_bits;

    assign addr_w  = {bus.host_addr[31:3], 3'b000};
    assign arg_off = addr_w - REG_ARGS_BASE;
    assign arg_hit = (addr_w >= REG_ARGS_BASE) &&
                     (arg_off[31:3] < 29'(NUM_ARG_WORDS));
    assign unused_addr_bits = ^{bus.host_addr[2:0], arg_off[2:0]};

    assign result_we_o  = bus.host_req && bus.host_wr && (addr_w == REG_RESULT);
    assign control_we_o = bus.host_req && bus.host_wr && (addr_w == REG_CONTROL);

    always_comb begin
        args_pad = '0;
        args_pad[MAX_ARG_WIDTH-1:0] = args_i;
        rd_mux = '0;
        case (addr_w)
            REG_STATUS: begin
                rd_mux[STAT_PENDING_BIT] = (state_i == ST_PENDING);
                rd_mux[STAT_RUN_BIT]     = run_i;
                rd_mux[STAT_RELEASE_BIT] = (state_i == ST_RELEASE);
            end
            REG_FUNC_ID:   rd_mux[FUNC_ID_WIDTH-1:0] = func_id_i;
            REG_RESULT:    rd_mux = result_i;
            // complete is a pulse, so it always reads back as 0
            REG_CONTROL:   rd_mux[CTRL_RUN_BIT] = run_i;
            REG_CYCLE_CNT: rd_mux = cycle_cnt_i;
            REG_CALL_CNT:  rd_mux[31:0] = call_cnt_i;
            default: begin
                if (arg_hit) begin
                    for (int i = 0; i < NUM_ARG_WORDS; i++) begin
                        if (arg_off[31:3] == 29'(i)) rd_mux = args_pad[i*64 +: 64];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= bus.host_req;
            rdata_q <= (bus.host_req && !bus.host_wr) ? rd_mux : 64'h0;
        end
    end

    assign bus.host_ack   = ack_q;
    assign bus.host_rdata = rdata_q;

endmodule

// File: rtl/loom_dpi_ctrl.sv
// FPGA-side DPI controller. Freezes the transformed DUT (clk_enable_o=0) on
// every DPI call, exposes the call through the host register window, and lets
// the DUT advance one cycle once the host writes the result and completes.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   dpi_valid_i/func_id_i/args_i   DPI call signalling from the DUT
//   dpi_result_o                   return value back to the DUT
//   clk_enable_o                   1 = DUT advances this cycle
//   host_*                         host register window (see loom_dpi_ctrl_if)
//   dbg_state_o                    current controller state
module loom_dpi_ctrl
    import loom_dpi_pkg::*;
#(
    parameter int FUNC_ID_WIDTH = 8,
    parameter int MAX_ARG_WIDTH = 512,
    parameter int MAX_RET_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dpi_valid_i,
    input  logic [FUNC_ID_WIDTH-1:0] dpi_func_id_i,
    input  logic [MAX_ARG_WIDTH-1:0] dpi_args_i,
    output logic [MAX_RET_WIDTH-1:0] dpi_result_o,
    output logic                     clk_enable_o,
    input  logic                     host_req_i,
    input  logic                     host_wr_i,
    input  logic [31:0]              host_addr_i,
    input  logic [63:0]              host_wdata_i,
    output logic [63:0]              host_rdata_o,
    output logic                     host_ack_o,
    output logic [1:0]               dbg_state_o
);
    dpi_state_e               state_q;
    logic                     run_q;
    logic [63:0]              result_q;
    logic [MAX_RET_WIDTH-1:0] dpi_result_q;
    logic [FUNC_ID_WIDTH-1:0] func_id_q;
    logic [MAX_ARG_WIDTH-1:0] args_q;
    logic [63:0]              cycle_cnt_q;
    logic [31:0]              call_cnt_q;
    logic                     result_we;
    logic                     control_we;
    logic                     complete;

    loom_dpi_ctrl_if host_if ();

    assign host_if.host_req   = host_req_i;
    assign host_if.host_wr    = host_wr_i;
    assign host_if.host_addr  = host_addr_i;
    assign host_if.host_wdata = host_wdata_i;
    assign host_rdata_o       = host_if.host_rdata;
    assign host_ack_o         = host_if.host_ack;

    loom_dpi_regfile #(
        .FUNC_ID_WIDTH (FUNC_ID_WIDTH),
        .MAX_ARG_WIDTH (MAX_ARG_WIDTH)
    ) u_regfile (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (host_if),
        .state_i      (state_q),
        .run_i        (run_q),
        .func_id_i    (func_id_q),
        .result_i     (result_q),
        .cycle_cnt_i  (cycle_cnt_q),
        .call_cnt_i   (call_cnt_q),
        .args_i       (args_q),
        .result_we_o  (result_we),
        .control_we_o (control_we)
    );

    assign complete = control_we && host_wdata_i[CTRL_COMPLETE_BIT];

    // Combinational so a freshly raised dpi_valid_i stops the DUT in the same
    // cycle; RELEASE grants exactly one advance regardless of dpi_valid_i.
    assign clk_enable_o = ((state_q == ST_IDLE) && run_q && !dpi_valid_i) ||
                          (state_q == ST_RELEASE);

    assign dpi_result_o = dpi_result_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            result_q     <= '0;
            dpi_result_q <= '0;
            func_id_q    <= '0;
            args_q       <= '0;
            cycle_cnt_q  <= '0;
            call_cnt_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 64'(clk_enable_o);
            if (result_we)  result_q <= host_wdata_i;
            // run is sampled by IDLE using its old value, so a call arriving
            // with a run=0 write on the same edge is still captured.
            if (control_we) run_q <= host_wdata_i[CTRL_RUN_BIT];
            case (state_q)
                ST_IDLE: begin
                    if (dpi_valid_i && run_q) begin
                        state_q    <= ST_PENDING;
                        func_id_q  <= dpi_func_id_i;
                        args_q     <= dpi_args_i;
                        call_cnt_q <= call_cnt_q + 32'd1;
                    end
                end
                ST_PENDING: begin
                    if (complete) begin
                        state_q      <= ST_RELEASE;
                        dpi_result_q <= result_q[MAX_RET_WIDTH-1:0];
                    end
                end
                ST_RELEASE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loom_dpi_ctrl.sv
module tb_loom_dpi_ctrl;
    import loom_dpi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         dpi_valid;
    logic [7:0]   dpi_func_id;
    logic [511:0] dpi_args;
    logic [63:0]  dpi_result;
    logic         clk_en;
    logic [1:0]   dbg_state;

    loom_dpi_ctrl_if bus ();

    loom_dpi_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .dpi_valid_i   (dpi_valid),
        .dpi_func_id_i (dpi_func_id),
        .dpi_args_i    (dpi_args),
        .dpi_result_o  (dpi_result),
        .clk_enable_o  (clk_en),
        .host_req_i    (bus.host_req),
        .host_wr_i     (bus.host_wr),
        .host_addr_i   (bus.host_addr),
        .host_wdata_i  (bus.host_wdata),
        .host_rdata_o  (bus.host_rdata),
        .host_ack_o    (bus.host_ack),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    bit          chk_q[$];
    logic [63:0] last_rdata = '0;
    logic        mon_req;
    logic [63:0] mon_exp;
    bit          mon_chk;

    // Ack must follow each request by exactly one cycle; data pops in order.
    always @(posedge clk) begin
        mon_req = bus.host_req;
        #2;
        n_tests++;
        assert (bus.host_ack === mon_req) else begin
            n_fail++;
            $error("FAIL ack_timing: got %b expected %b", bus.host_ack, mon_req);
        end
        if (bus.host_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL ack_unexpected: got ack expected none");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_chk = chk_q.pop_front();
                last_rdata = bus.host_rdata;
                if (mon_chk) begin
                    n_tests++;
                    assert (bus.host_rdata === mon_exp) else begin
                        n_fail++;
                        $error("FAIL rdata: got 0x%0h expected 0x%0h", bus.host_rdata, mon_exp);
                    end
                end
            end
        end else begin
            n_tests++;
            assert (bus.host_rdata === 64'h0) else begin
                n_fail++;
                $error("FAIL rdata_idle: got 0x%0h expected 0x0", bus.host_rdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic host_write(input logic [31:0] a, input logic [63:0] d);
        bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        exp_q.push_back(64'h0); chk_q.push_back(1'b1);
        @(negedge clk);
        bus.host_req = 1'b0; bus.host_wr = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] a, input logic [63:0] e, input bit c);
        bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = a; bus.host_wdata = '0;
        exp_q.push_back(e); chk_q.push_back(c);
        @(negedge clk);
        bus.host_req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [511:0] args_a;
    logic [511:0] args_g;
    logic [31:0]  burst_addr[3];
    logic [63:0]  burst_exp[3];

    initial begin
        bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        dpi_valid = 1'b0; dpi_func_id = '0; dpi_args = '0;
        args_a = '0;
        args_a[63:0]    = 64'hDEAD_BEEF;
        args_a[127:64]  = 64'h1234;
        args_a[511:448] = 64'h7777;
        for (int i = 0; i < 8; i++) args_g[i*64 +: 64] = 64'hA000_0000_0000_0000 + 64'(i);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_en", {63'b0, clk_en}, 64'h0);
        chk("rst_result", dpi_result, 64'h0);
        chk("rst_ack", {63'b0, bus.host_ack}, 64'h0);
        chk("rst_state", {62'b0, dbg_state}, 64'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_norun_clk_en", {63'b0, clk_en}, 64'h0);

        // run
        host_write(REG_CONTROL, 64'h2);
        chk("run_clk_en", {63'b0, clk_en}, 64'h1);
        host_read(REG_STATUS, 64'h2, 1'b1);
        repeat (10) @(negedge clk);
        host_read(REG_CYCLE_CNT, 64'h0, 1'b0);
        n_tests++;
        assert (last_rdata >= 64'd10) else begin
            n_fail++;
            $error("FAIL cycle_cnt: got %0d expected >= 10", last_rdata);
        end

        // first call: DUT freezes in the same cycle
        dpi_valid = 1'b1; dpi_func_id = 8'h2A; dpi_args = args_a;
        #1;
        chk("call_clk_en_same_cycle", {63'b0, clk_en}, 64'h0);
        @(negedge clk);
        chk("pending_state", {62'b0, dbg_state}, 64'(ST_PENDING));
        // DUT inputs move while frozen; the captured copy must not
        dpi_args = args_g;
        host_read(REG_STATUS, 64'h3, 1'b1);
        host_read(REG_FUNC_ID, 64'h2A, 1'b1);
        host_read(REG_ARGS_BASE, 64'hDEAD_BEEF, 1'b1);
        host_read(REG_ARGS_BASE + 32'h8, 64'h1234, 1'b1);
        host_read(REG_ARGS_BASE + 32'h38, 64'h7777, 1'b1);
        host_read(REG_ARGS_BASE + 32'h40, 64'h0, 1'b1);
        host_read(REG_CALL_CNT, 64'h1, 1'b1);
        host_read(REG_CONTROL, 64'h2, 1'b1);
        chk("pending_clk_en", {63'b0, clk_en}, 64'h0);

        // complete with dpi_valid still high
        host_write(REG_RESULT, 64'h55);
        host_read(REG_RESULT, 64'h55, 1'b1);
        host_write(REG_CONTROL, 64'h3);
        chk("release_result", dpi_result, 64'h55);
        chk("release_clk_en", {63'b0, clk_en}, 64'h1);
        host_read(REG_STATUS, 64'h6, 1'b1);
        chk("post_release_clk_en", {63'b0, clk_en}, 64'h0);
        @(negedge clk);
        chk("recapture_state", {62'b0, dbg_state}, 64'(ST_PENDING));
        host_read(REG_CALL_CNT, 64'h2, 1'b1);
        host_read(REG_ARGS_BASE, args_g[63:0], 1'b1);

        // run=0 while pending: takes effect after release
        dpi_valid = 1'b0;
        host_write(REG_CONTROL, 64'h0);
        host_read(REG_STATUS, 64'h1, 1'b1);
        host_write(REG_CONTROL, 64'h1);
        chk("release2_clk_en", {63'b0, clk_en}, 64'h1);
        @(negedge clk);
        chk("stopped_clk_en", {63'b0, clk_en}, 64'h0);
        host_read(REG_CONTROL, 64'h0, 1'b1);

        // complete while idle, RO write, unmapped read, ignored low address bits
        host_write(REG_CONTROL, 64'h1);
        host_read(REG_STATUS, 64'h0, 1'b1);
        host_write(REG_FUNC_ID, 64'hFF);
        host_read(32'h0000_000C, 64'h2A, 1'b1);
        host_read(32'h0000_0030, 64'h0, 1'b1);

        // back-to-back reads
        burst_addr[0] = REG_FUNC_ID;   burst_exp[0] = 64'h2A;
        burst_addr[1] = REG_ARGS_BASE; burst_exp[1] = args_g[63:0];
        burst_addr[2] = REG_STATUS;    burst_exp[2] = 64'h0;
        for (int i = 0; i < 3; i++) begin
            bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = burst_addr[i];
            exp_q.push_back(burst_exp[i]); chk_q.push_back(1'b1);
            @(negedge clk);
        end
        bus.host_req = 1'b0;
        @(negedge clk);

        // asynchronous reset drops the clock enable at once
        host_write(REG_CONTROL, 64'h2);
        chk("rerun_clk_en", {63'b0, clk_en}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clk_en", {63'b0, clk_en}, 64'h0);
        chk("async_rst_result", dpi_result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        host_read(REG_STATUS, 64'h0, 1'b1);

        // reset while pending
        host_write(REG_CONTROL, 64'h2);
        dpi_valid = 1'b1; dpi_func_id = 8'h11;
        @(negedge clk);
        chk("pending2_state", {62'b0, dbg_state}, 64'(ST_PENDING));
        #2 rst_n = 1'b0;
        #1;
        chk("pending_rst_clk_en", {63'b0, clk_en}, 64'h0);
        chk("pending_rst_state", {62'b0, dbg_state}, 64'(ST_IDLE));
        dpi_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        host_read(REG_STATUS, 64'h0, 1'b1);
        host_read(REG_CALL_CNT, 64'h0, 1'b1);
        host_read(REG_FUNC_ID, 64'h0, 1'b1);
        chk("post_rst_result", dpi_result, 64'h0);
        chk("post_rst_clk_en", {63'b0, clk_en}, 64'h0);

        // drain scoreboard (bounded)
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: got %0d outstanding expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
